// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_pkg
//  Description : Shared types for the data-memory responder slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [7:0] byte_t;

    // Lane 0 is the most significant byte and maps to addr+0
    typedef byte_t [0:WORD_BYTES-1] word_lanes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Misaligned or beyond the backing store; addresses never wrap
    function automatic logic access_err(input logic [31:0] addr, input logic [32:0] mem_bytes);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= mem_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : data_mem_responder_if
//  Description : Word request/response bus between core (master) and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    word_lanes_t req_wdata;
    logic        resp_valid;
    word_lanes_t resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : byte_ram
//  Description : Byte-addressed store, 4-lane aligned write, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_ram
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    localparam int c_AW      = $clog2(MEM_BYTES),
    localparam int c_WORD_AW = (c_AW > 2) ? c_AW - 2 : 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_wr_en,
    input  wire logic                 i_rd_en,
    input  wire logic                 i_rd_clr,
    input  wire logic [c_WORD_AW-1:0] i_word_addr,
    input  wire word_lanes_t          i_wr_lanes,
    output word_lanes_t               o_rd_lanes
);

    localparam int c_WORDS = MEM_BYTES / WORD_BYTES;

    // One bank per lane: byte addr+k lives in bank k at the word index
    generate
        for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
            byte_t r_bank [c_WORDS];
            byte_t r_rd;

            always_ff @(posedge clk) begin
                if (i_wr_en) begin
                    r_bank[i_word_addr] <= i_wr_lanes[k];
                end
            end

            always_ff @(posedge clk) begin
                if (rst || i_rd_clr) begin
                    r_rd <= '0;
                end else if (i_rd_en) begin
                    r_rd <= r_bank[i_word_addr];
                end
            end

            assign o_rd_lanes[k] = r_rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data-memory responder with fixed latency and error detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    parameter int LATENCY   = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    data_mem_responder_if.slave bus
);

    localparam int c_AW      = $clog2(MEM_BYTES);
    localparam int c_WORD_AW = (c_AW > 2) ? c_AW - 2 : 1;
    localparam int c_CW      = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [c_CW-1:0]       r_cnt;
    logic [c_CW-1:0]       w_cnt_nxt;

    logic                  r_we;
    logic                  r_err;
    logic [31:0]           r_addr;
    word_lanes_t           r_wdata;

    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic                  r_busy;

    logic                  w_hs;
    logic                  w_enter_resp;
    logic                  w_acc_we;
    logic                  w_acc_err;
    logic [31:0]           w_acc_addr;
    word_lanes_t           w_acc_wdata;
    logic [c_WORD_AW-1:0]  w_word_addr;
    word_lanes_t           w_rd_lanes;

    assign bus.req_ready = (r_state == IDLE) && !rst;
    assign w_hs          = bus.req_valid && bus.req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CW'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_resp_valid <= (w_state_nxt == RESP);
            r_resp_err   <= (w_state_nxt == RESP) && w_acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_hs) begin
            r_we    <= bus.req_we;
            r_err   <= access_err(bus.req_addr, 33'(MEM_BYTES));
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // With LATENCY==1 the array access coincides with the handshake edge,
    // so the live request is used while still in IDLE
    assign w_acc_we    = (r_state == IDLE) ? bus.req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
    assign w_acc_err   = (r_state == IDLE) ? access_err(bus.req_addr, 33'(MEM_BYTES)) : r_err;

    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP) && !rst;
    assign w_word_addr  = c_WORD_AW'(w_acc_addr >> 2);

    byte_ram #(
        .MEM_BYTES (MEM_BYTES)
    ) u_byte_ram (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_enter_resp &&  w_acc_we && !w_acc_err),
        .i_rd_en     (w_enter_resp && !w_acc_we && !w_acc_err),
        .i_rd_clr    (w_enter_resp && (w_acc_we || w_acc_err)),
        .i_word_addr (w_word_addr),
        .i_wr_lanes  (w_acc_wdata),
        .o_rd_lanes  (w_rd_lanes)
    );

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = w_rd_lanes;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench: vector table, random traffic vs model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if ifa();
    data_mem_responder_if ifb();
    data_mem_responder_if ifc();

    data_mem_responder #(.MEM_BYTES(256),   .LATENCY(2)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    data_mem_responder #(.MEM_BYTES(256),   .LATENCY(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    data_mem_responder #(.MEM_BYTES(65536), .LATENCY(5)) u_dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int lat_of [3] = '{2, 1, 5};
    int size_of [3] = '{256, 256, 65536};

    // Reference byte store: key = instance * 2^20 + byte address
    byte_t mdl [int];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int key(input int w, input logic [31:0] a);
        return w * (1 << 20) + int'(a);
    endfunction

    function automatic logic rd_ready(input int w);
        case (w)
            0:       return ifa.req_ready;
            1:       return ifb.req_ready;
            default: return ifc.req_ready;
        endcase
    endfunction

    function automatic logic rd_rv(input int w);
        case (w)
            0:       return ifa.resp_valid;
            1:       return ifb.resp_valid;
            default: return ifc.resp_valid;
        endcase
    endfunction

    function automatic logic rd_err(input int w);
        case (w)
            0:       return ifa.resp_err;
            1:       return ifb.resp_err;
            default: return ifc.resp_err;
        endcase
    endfunction

    function automatic logic [31:0] rd_rdata(input int w);
        case (w)
            0:       return ifa.resp_rdata;
            1:       return ifb.resp_rdata;
            default: return ifc.resp_rdata;
        endcase
    endfunction

    function automatic logic rd_busy(input int w);
        case (w)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        case (w)
            0: begin ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.req_wdata = d; end
            1: begin ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.req_wdata = d; end
            default: begin ifc.req_valid = v; ifc.req_we = we; ifc.req_addr = a; ifc.req_wdata = d; end
        endcase
    endtask

    // Latency = negedges after the handshake edge until resp_valid is seen
    task automatic xact(input int w, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic err, output logic [31:0] rdata, output int lat);
        int budget;
        err = 1'b0; rdata = '0; lat = -1;
        @(negedge clk);
        drive(w, 1'b1, we, a, d);
        budget = 50;
        while (!rd_ready(w) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: inst %0d ready stayed 0, expected 1", w);
            drive(w, 1'b0, 1'b0, '0, '0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, ~we, ~a, ~d);
        lat = 1; budget = 50;
        while (!rd_rv(w) && budget > 0) begin
            @(negedge clk);
            lat++; budget--;
        end
        if (budget == 0) begin
            lat = -1;
            return;
        end
        err   = rd_err(w);
        rdata = rd_rdata(w);
    endtask

    // Expectation comes from the model; model is updated after a good write
    task automatic model_xact(input int w, input logic we, input logic [31:0] a, input logic [31:0] d, input string name);
        logic        err, exp_err, known;
        logic [31:0] rdata, exp_rd;
        int          lat;
        exp_err = (a % 4 != 0) || (longint'(a) >= longint'(size_of[w]));
        known   = 1'b1;
        exp_rd  = '0;
        if (!exp_err && !we) begin
            for (int k = 0; k < 4; k++) begin
                if (!mdl.exists(key(w, a + k))) known = 1'b0;
                else exp_rd = {exp_rd[23:0], mdl[key(w, a + k)]};
            end
        end
        xact(w, we, a, d, err, rdata, lat);
        check($sformatf("%s_latency", name), lat, lat_of[w]);
        check($sformatf("%s_err", name), err, exp_err);
        if (exp_err || we || known) check($sformatf("%s_rdata", name), rdata, exp_rd);
        if (!exp_err && we) begin
            for (int k = 0; k < 4; k++) mdl[key(w, a + k)] = d[31 - 8 * k -: 8];
        end
    endtask

    logic [2:0] prev_rv = '0;
    always @(negedge clk) begin
        logic [2:0] rv;
        rv = {ifc.resp_valid, ifb.resp_valid, ifa.resp_valid};
        for (int i = 0; i < 3; i++) begin
            if (rv[i]) begin
                n_checks++;
                if (prev_rv[i]) begin
                    n_fail++;
                    $display("FAIL resp_pulse_width: inst %0d resp_valid high 2 cycles, expected 1", i);
                end
            end
        end
        prev_rv = rv;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        logic        err;
        logic [31:0] rdata, a, d;
        int          lat, hs [$], rv_cnt;

        for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            check($sformatf("reset_ready_%0d", w), rd_ready(w), 1'b0);
            check($sformatf("reset_busy_%0d", w), rd_busy(w), 1'b0);
            check($sformatf("reset_outs_%0d", w), {rd_rv(w), rd_err(w), rd_rdata(w)}, '0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 3; w++) check($sformatf("post_reset_ready_%0d", w), rd_ready(w), 1'b1);

        // Directed vector table on instance A (LATENCY=2, MEM_BYTES=256)
        tbl.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b0, 32'h13,       32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 32'h13,       32'h12345678, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 32'h100,      32'h55667788, 1'b1, 32'h0});
        tbl.push_back('{1'b1, 32'hFC,       32'hCAFEF00D, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 32'hFC,       32'h0,        1'b0, 32'hCAFEF00D});
        tbl.push_back('{1'b0, 32'h100,      32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0});
        for (int i = 0; i < tbl.size(); i++) begin
            xact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, err, rdata, lat);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
            if (tbl[i].we && !tbl[i].exp_err)
                for (int k = 0; k < 4; k++) mdl[key(0, tbl[i].addr + k)] = tbl[i].wdata[31 - 8 * k -: 8];
        end

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = $urandom_range(0, 63) * 4;
                2:       a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
                default: a = 256 + $urandom_range(0, 1000);
            endcase
            d = $urandom;
            model_xact(0, 1'($urandom_range(0, 1)), a, d, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Back-to-back with req_valid held high
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, '0);
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("b2b_ready_vs_busy_%0d", c), ifa.req_ready, !ifa.busy);
            if (ifa.req_ready) hs.push_back(c);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        check("b2b_handshake_count", hs.size(), 5);
        for (int i = 1; i < hs.size(); i++)
            check($sformatf("b2b_interval_%0d", i), hs[i] - hs[i-1], 3);
        repeat (5) @(negedge clk);

        // LATENCY=1 and LATENCY=5 instances
        model_xact(1, 1'b1, 32'h40,    32'h01020304, "lat1_wr");
        model_xact(1, 1'b0, 32'h40,    32'h0,        "lat1_rd");
        model_xact(1, 1'b0, 32'h41,    32'h0,        "lat1_misaligned");
        model_xact(2, 1'b1, 32'h8000,  32'hA5A55A5A, "lat5_wr");
        model_xact(2, 1'b0, 32'h8000,  32'h0,        "lat5_rd");
        model_xact(2, 1'b1, 32'h10000, 32'h0BADF00D, "lat5_oor");
        model_xact(2, 1'b0, 32'hFFFC,  32'h0,        "lat5_top");

        // Reset while a write sits in WAIT
        model_xact(0, 1'b1, 32'h20, 32'hA1B2C3D4, "pre_rst_wr");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h11223344);
        check("rst_seq_ready", ifa.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        check("rst_seq_busy_wait", ifa.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_seq_ready_low", ifa.req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_seq_busy_cleared", ifa.busy, 1'b0);
        rv_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("rst_seq_ready_back", ifa.req_ready, 1'b1);
            if (ifa.resp_valid) rv_cnt++;
        end
        check("rst_seq_no_resp", rv_cnt, 0);
        model_xact(0, 1'b0, 32'h20, 32'h0, "post_rst_rd");
        xact(0, 1'b0, 32'h20, 32'h0, err, rdata, lat);
        check("post_rst_rd_const", rdata, 32'hA1B2C3D4);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
